// File: rtl/pkt_transmitter_mc_if.sv
// rtl/pkt_transmitter_mc_if.sv - packet input/output stream bundle for the multi-channel transmitter
interface pkt_transmitter_mc_if #(
    parameter int NUM_CH = 2,
    parameter int W_PKT  = 134
);
    logic [NUM_CH-1:0]       pktin_data_wr;
    logic [NUM_CH*W_PKT-1:0] pktin_data;
    logic [NUM_CH-1:0]       pktin_ready;
    logic                    pktout_data_wr;
    logic [W_PKT-1:0]        pktout_data;
    logic                    pktout_data_valid_wr;
    logic                    pktout_data_valid;
    logic                    pktout_ready;

    modport master (
        output pktin_data_wr, pktin_data, pktout_ready,
        input  pktin_ready, pktout_data_wr, pktout_data, pktout_data_valid_wr, pktout_data_valid
    );

    modport slave (
        input  pktin_data_wr, pktin_data, pktout_ready,
        output pktin_ready, pktout_data_wr, pktout_data, pktout_data_valid_wr, pktout_data_valid
    );
endinterface

// File: rtl/pkt_transmitter_mc.sv
// rtl/pkt_transmitter_mc.sv - per-channel packet FIFOs with round-robin whole-packet output and metadata rewrite
module pkt_transmitter_mc #(
    parameter int NUM_CH       = 2,
    parameter int W_PKT        = 134,
    parameter int FIFO_AW      = 8,
    parameter int READY_THRESH = 200,
    parameter int LMID         = 9,
    parameter int MID_DST      = 132,
    parameter int TAG_BIT      = 34,
    parameter bit DROP_EN      = 1'b1,
    parameter int DROP_BIT     = 35
) (
    input  logic                  clk,
    input  logic                  reset,
    pkt_transmitter_mc_if.slave   bus,
    input  logic                  cin_data_wr,
    input  logic [W_PKT-1:0]      cin_data,
    output logic                  cin_ready,
    output logic                  cout_data_wr,
    output logic [W_PKT-1:0]      cout_data,
    input  logic                  cout_ready,
    output logic [NUM_CH-1:0]     ovf,
    output logic [31:0]           pkt_count
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [FIFO_AW:0] FULL   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] THRESH = (FIFO_AW + 1)'(READY_THRESH);
    localparam logic [1:0] MARK_TAIL = 2'b10;

    typedef enum logic [1:0] {IDLE, META, BODY} state_t;

    state_t                     state, state_n;
    logic [CW-1:0]              g, rr_ptr, grant;
    logic [CW:0]                rr_sum;
    logic                       any_elig, pop, out_wr, out_vwr, drop_q;
    logic [NUM_CH-1:0]          eligible, rdy_vec;
    logic [NUM_CH-1:0][W_PKT-1:0] head_flit;
    logic [W_PKT-1:0]           cur_flit, out_flit, data_hold;

    assign cin_ready    = cout_ready;
    assign cout_data_wr = cin_data_wr;
    assign cout_data    = cin_data;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [W_PKT-1:0]   mem [DEPTH];
        logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
        logic [FIFO_AW:0]   used, pkts;
        logic               ovf_q, rdy_q, wr_ok, rd, tail_in, tail_out;
        logic [W_PKT-1:0]   din;

        assign din           = bus.pktin_data[c*W_PKT +: W_PKT];
        assign wr_ok         = bus.pktin_data_wr[c] && (used != FULL);
        assign rd            = pop && (g == CW'(c));
        assign tail_in       = wr_ok && (din[W_PKT-1 -: 2] == MARK_TAIL);
        assign tail_out      = rd && (mem[rd_ptr][W_PKT-1 -: 2] == MARK_TAIL);
        assign head_flit[c]  = mem[rd_ptr];
        // Only complete packets make a channel eligible, so a started packet never underruns.
        assign eligible[c]   = (pkts != '0);
        assign ovf[c]        = ovf_q;
        assign rdy_vec[c]    = rdy_q;

        always_ff @(posedge clk) begin
            if (wr_ok) mem[wr_ptr] <= din;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                used   <= '0;
                pkts   <= '0;
                ovf_q  <= 1'b0;
                rdy_q  <= 1'b1;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
                if (rd)    rd_ptr <= rd_ptr + FIFO_AW'(1);
                if (wr_ok && !rd)      used <= used + (FIFO_AW + 1)'(1);
                else if (!wr_ok && rd) used <= used - (FIFO_AW + 1)'(1);
                if (tail_in && !tail_out)      pkts <= pkts + (FIFO_AW + 1)'(1);
                else if (!tail_in && tail_out) pkts <= pkts - (FIFO_AW + 1)'(1);
                if (bus.pktin_data_wr[c] && !wr_ok) ovf_q <= 1'b1;
                rdy_q <= (used < THRESH);
            end
        end
    end

    assign bus.pktin_ready = rdy_vec;

    // First eligible channel at or after rr_ptr, wrapping past NUM_CH-1.
    always_comb begin
        any_elig = 1'b0;
        grant    = '0;
        rr_sum   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_sum = {1'b0, rr_ptr} + (CW + 1)'(i);
            if (rr_sum >= (CW + 1)'(NUM_CH)) rr_sum = rr_sum - (CW + 1)'(NUM_CH);
            if (!any_elig && eligible[rr_sum[CW-1:0]]) begin
                any_elig = 1'b1;
                grant    = rr_sum[CW-1:0];
            end
        end
    end

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        out_wr   = 1'b0;
        out_vwr  = 1'b0;
        cur_flit = head_flit[g];
        out_flit = cur_flit;
        case (state)
            IDLE: begin
                if (bus.pktout_ready && any_elig) state_n = META;
            end
            META: begin
                pop    = 1'b1;
                out_wr = 1'b1;
                if (cur_flit[TAG_BIT]) begin
                    out_flit[126]   = 1'b1;
                    out_flit[95:88] = 8'(LMID);
                    out_flit[87:80] = 8'(MID_DST);
                end
                state_n = BODY;
            end
            BODY: begin
                pop    = 1'b1;
                out_wr = 1'b1;
                if (cur_flit[W_PKT-1 -: 2] == MARK_TAIL) begin
                    out_vwr = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            g         <= '0;
            rr_ptr    <= '0;
            drop_q    <= 1'b0;
            pkt_count <= '0;
            data_hold <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == META) g <= grant;
            if (state == META) drop_q <= DROP_EN & cur_flit[DROP_BIT];
            if (out_vwr) begin
                pkt_count <= pkt_count + 32'd1;
                rr_ptr    <= (g == CW'(NUM_CH - 1)) ? '0 : g + CW'(1);
            end
            if (out_wr) data_hold <= out_flit;
        end
    end

    assign bus.pktout_data_wr       = out_wr;
    assign bus.pktout_data          = out_wr ? out_flit : data_hold;
    assign bus.pktout_data_valid_wr = out_vwr;
    assign bus.pktout_data_valid    = out_vwr & ~drop_q;
endmodule
